// File: rtl/spi_master_cfg_if.sv
// rtl/spi_master_cfg_if.sv - request/config/result bundle between the bus front-end and the SPI master
interface spi_master_cfg_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8,
    parameter int CS_W       = 1
) ();
    logic                  start;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DIV_WIDTH-1:0]  clk_div;
    logic                  cpol;
    logic                  cpha;
    logic                  lsb_first;
    logic [CS_W-1:0]       cs_sel;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  new_data;

    modport master (
        output start, data_in, clk_div, cpol, cpha, lsb_first, cs_sel,
        input  busy, data_out, new_data
    );

    modport slave (
        input  start, data_in, clk_div, cpol, cpha, lsb_first, cs_sel,
        output busy, data_out, new_data
    );
endinterface

// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - configurable-width, four-mode SPI master with decoded chip selects
module spi_master_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8,
    parameter int NUM_CS     = 1
) (
    input  logic              clk,
    input  logic              rst,
    spi_master_cfg_if.slave   io_bus,
    input  logic              i_miso,
    output logic              o_mosi,
    output logic              o_sck,
    output logic [NUM_CS-1:0] o_cs_n
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int EW   = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [EW-1:0] EDGES     = EW'(2 * DATA_WIDTH);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t                r_state, w_state_nxt;
    logic [DIV_WIDTH-1:0]  r_div, w_div_nxt;
    logic [DIV_WIDTH-1:0]  r_cnt, w_cnt_nxt;
    logic [EW-1:0]         r_edge, w_edge_nxt;
    logic                  r_cpol, w_cpol_nxt;
    logic                  r_cpha, w_cpha_nxt;
    logic                  r_lsb, w_lsb_nxt;
    logic [DATA_WIDTH-1:0] r_tx, w_tx_nxt;
    logic [DATA_WIDTH-1:0] r_rx, w_rx_nxt;
    logic [DATA_WIDTH-1:0] r_dout, w_dout_nxt;
    logic                  r_sck, w_sck_nxt;
    logic                  r_mosi, w_mosi_nxt;
    logic [NUM_CS-1:0]     r_cs_n, w_cs_n_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_new, w_new_nxt;

    logic [CS_W-1:0]       w_cs_sel;
    logic [NUM_CS-1:0]     w_cs_dec;
    logic                  w_half_done;
    logic                  w_edge;
    logic                  w_leading;
    logic                  w_sample;
    logic                  w_drive;

    assign w_cs_sel = io_bus.cs_sel;

    // Out-of-range selects match no index and leave every chip select released.
    always_comb begin
        w_cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(w_cs_sel) == i) w_cs_dec[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_edge  <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_dout  <= '0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= '1;
            r_busy  <= 1'b0;
            r_new   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_cnt   <= w_cnt_nxt;
            r_edge  <= w_edge_nxt;
            r_cpol  <= w_cpol_nxt;
            r_cpha  <= w_cpha_nxt;
            r_lsb   <= w_lsb_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_dout  <= w_dout_nxt;
            r_sck   <= w_sck_nxt;
            r_mosi  <= w_mosi_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_busy  <= w_busy_nxt;
            r_new   <= w_new_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;
        w_edge_nxt  = r_edge;
        w_cpol_nxt  = r_cpol;
        w_cpha_nxt  = r_cpha;
        w_lsb_nxt   = r_lsb;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_dout_nxt  = r_dout;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        w_cs_n_nxt  = r_cs_n;
        w_busy_nxt  = r_busy;
        w_new_nxt   = 1'b0;
        w_edge      = 1'b0;
        w_half_done = (r_cnt == r_div);

        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_state_nxt = S_SETUP;
                    w_div_nxt   = io_bus.clk_div;
                    w_cpol_nxt  = io_bus.cpol;
                    w_cpha_nxt  = io_bus.cpha;
                    w_lsb_nxt   = io_bus.lsb_first;
                    w_cnt_nxt   = '0;
                    w_edge_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                    w_cs_n_nxt  = w_cs_dec;
                    w_sck_nxt   = io_bus.cpol;
                    w_tx_nxt    = io_bus.data_in;
                    // Mode 0/2 must present the first bit before the first sampling edge.
                    if (!io_bus.cpha) begin
                        w_mosi_nxt = io_bus.lsb_first ? io_bus.data_in[0]
                                                      : io_bus.data_in[DATA_WIDTH-1];
                        w_tx_nxt   = io_bus.lsb_first ? (io_bus.data_in >> 1)
                                                      : (io_bus.data_in << 1);
                    end
                end
            end
            S_SETUP: begin
                if (w_half_done) begin
                    w_cnt_nxt   = '0;
                    w_edge      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_half_done) begin
                    w_cnt_nxt = '0;
                    if (r_edge == EDGES) w_state_nxt = S_HOLD;
                    else                 w_edge      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (w_half_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_cs_n_nxt  = '1;
                    w_dout_nxt  = r_rx;
                    w_new_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Even edge indices move sck away from idle (leading), odd ones return it.
        w_leading = ~r_edge[0];
        w_sample  = r_cpha ? ~w_leading : w_leading;
        w_drive   = r_cpha ? w_leading : (~w_leading && (r_edge != LAST_EDGE));

        if (w_edge) begin
            w_sck_nxt  = ~r_sck;
            w_edge_nxt = r_edge + 1'b1;
            if (w_sample) begin
                w_rx_nxt = r_lsb ? {i_miso, r_rx[DATA_WIDTH-1:1]}
                                 : {r_rx[DATA_WIDTH-2:0], i_miso};
            end
            if (w_drive) begin
                w_mosi_nxt = r_lsb ? r_tx[0] : r_tx[DATA_WIDTH-1];
                w_tx_nxt   = r_lsb ? (r_tx >> 1) : (r_tx << 1);
            end
        end
    end

    assign o_mosi          = r_mosi;
    assign o_sck           = r_sck;
    assign o_cs_n          = r_cs_n;
    assign io_bus.busy     = r_busy;
    assign io_bus.data_out = r_dout;
    assign io_bus.new_data = r_new;
endmodule
